// File: rtl/inst_sram_axi_resp.sv
// Fetch-port responder: turns one 8-byte-aligned SRAM-style fetch into a
// 2-beat AXI4 INCR read and returns both instructions packed into 64 bits.
module inst_sram_axi_resp #(
  parameter int              ID_W  = 4,
  parameter logic [ID_W-1:0] AR_ID = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_sram_en,
  input  logic [3:0]      inst_sram_wen,
  input  logic [31:0]     inst_sram_addr,
  input  logic [31:0]     inst_sram_wdata,
  input  logic            flush,
  output logic            stall,
  output logic [63:0]     inst_rdata,
  output logic            inst_rvalid,
  output logic            inst_err,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        discard_q, discard_d;
  logic        beat_q, beat_d;

  // Writes, write data, rid and the byte offset carry no meaning for this port.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, rid, inst_sram_addr[2:0]};

  assign arid        = AR_ID;
  assign araddr      = {addr_q, 3'b000};
  assign arlen       = 8'd1;
  assign arsize      = 3'd2;
  assign arburst     = 2'b01;
  assign inst_rdata  = rdata_q;
  assign inst_err    = err_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      beat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      beat_q    <= beat_d;
    end
  end

  // AXI channels: a transfer happens on a rising edge where valid && ready;
  // arvalid, once raised, is held with a stable address until arready.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    discard_d   = discard_q;
    beat_d      = beat_q;
    stall       = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    inst_rvalid = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = inst_sram_en;
        if (inst_sram_en && !flush) begin
          addr_d    = inst_sram_addr[31:3];
          rdata_d   = '0;
          err_d     = 1'b0;
          beat_d    = 1'b0;
          discard_d = 1'b0;
          state_d   = S_AR;
        end
      end
      S_AR: begin
        stall   = 1'b1;
        arvalid = 1'b1;
        if (flush) discard_d = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        stall  = 1'b1;
        rready = 1'b1;
        // A redirected fetch still drains its burst; only the result is dropped.
        if (flush) discard_d = 1'b1;
        if (rvalid) begin
          if (!beat_q) begin
            rdata_d[31:0] = rdata;
            beat_d        = 1'b1;
          end else begin
            rdata_d[63:32] = rdata;
          end
          if (rresp != 2'b00) err_d = 1'b1;
          if (rlast) begin
            if (!beat_q) err_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        inst_rvalid = !discard_q && !flush;
        discard_d   = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_sram_axi_resp.sv
// Directed bench for inst_sram_axi_resp: inputs change on the falling edge,
// outputs are checked 1 ns later, state advances on the rising edge.
module tb_inst_sram_axi_resp;

  logic        clk;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        flush;
  logic        stall;
  logic [63:0] inst_rdata;
  logic        inst_rvalid;
  logic        inst_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  inst_sram_axi_resp #(.ID_W(4), .AR_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .flush(flush), .stall(stall), .inst_rdata(inst_rdata),
    .inst_rvalid(inst_rvalid), .inst_err(inst_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One AXI read beat preceded by `gap` idle cycles on the R channel.
  task automatic beat(input int gap, input logic [31:0] d, input logic [1:0] resp, input logic last);
    for (int i = 0; i < gap; i++) begin
      rvalid = 1'b0;
      #1;
      chk("gap_rready", rready, 1);
      chk("gap_stall", stall, 1);
      @(negedge clk);
    end
    rvalid = 1'b1; rdata = d; rresp = resp; rlast = last;
    #1;
    chk("beat_rready", rready, 1);
    chk("beat_stall", stall, 1);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  // Full fetch. fmode: 0 none, 1 flush after beat 0, 2 flush in DONE.
  task automatic fetch(input logic [31:0] addr, input int ar_wait, input int gap,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] r0, input logic [1:0] r1, input logic early,
                       input int fmode, input logic [63:0] exp_data, input logic exp_err);
    logic exp_rv;
    exp_rv = (fmode == 0);
    inst_sram_en = 1'b1; inst_sram_addr = addr;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_state", dbg_state, 0);
    @(negedge clk);
    inst_sram_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < ar_wait; i++) begin
      arready = 1'b0;
      #1;
      chk("ar_wait_arvalid", arvalid, 1);
      chk("ar_wait_araddr", araddr, {addr[31:3], 3'b000});
      chk("ar_wait_stall", stall, 1);
      @(negedge clk);
    end
    arready = 1'b1;
    #1;
    chk("ar_arvalid", arvalid, 1);
    chk("ar_araddr", araddr, {addr[31:3], 3'b000});
    chk("ar_arlen", arlen, 8'd1);
    chk("ar_arsize", arsize, 3'd2);
    chk("ar_arburst", arburst, 2'b01);
    chk("ar_arid", arid, 4'd0);
    @(negedge clk);
    arready = 1'b0;
    beat(gap, d0, r0, early);
    if (!early) begin
      if (fmode == 1) flush = 1'b1;
      beat(gap, d1, r1, 1'b1);
      flush = 1'b0;
    end
    inst_sram_en = 1'b0;
    flush = (fmode == 2);
    #1;
    chk("done_state", dbg_state, 3);
    chk("done_stall", stall, 0);
    chk("done_rvalid", inst_rvalid, exp_rv);
    if (exp_rv) begin
      chk("done_rdata", inst_rdata, exp_data);
      chk("done_err", inst_err, exp_err);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("post_state", dbg_state, 0);
    chk("post_rvalid", inst_rvalid, 0);
    chk("post_stall", stall, 0);
  endtask

  initial begin
    reset = 1'b1; inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = '0;
    inst_sram_wdata = '0; flush = 1'b0; arready = 1'b0; rid = '0; rdata = '0;
    rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rvalid", inst_rvalid, 0);
    chk("rst_err", inst_err, 0);
    chk("rst_rdata", inst_rdata, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: basic fetch, unaligned address, immediate arready
    fetch(32'hBFC0_0004, 0, 0, 32'h1111_1111, 32'h2222_2222, 2'b00, 2'b00, 1'b0, 0,
          64'h2222_2222_1111_1111, 1'b0);
    // 2: arready held off for 5 cycles, write strobes set (treated as read)
    inst_sram_wen = 4'hF;
    fetch(32'h1FC0_0120, 5, 0, 32'hA5A5_0001, 32'h5A5A_0002, 2'b00, 2'b00, 1'b0, 0,
          64'h5A5A_0002_A5A5_0001, 1'b0);
    inst_sram_wen = 4'h0;
    // 3: flush after beat 0 drains the burst silently, then a normal fetch
    fetch(32'h0000_1000, 0, 0, 32'h0BAD_0000, 32'h0BAD_0001, 2'b00, 2'b00, 1'b0, 1,
          64'h0, 1'b0);
    fetch(32'h8000_0010, 1, 0, 32'h3333_3333, 32'h4444_4444, 2'b00, 2'b00, 1'b0, 0,
          64'h4444_4444_3333_3333, 1'b0);
    // 4: SLVERR on beat 1, then clean fetch clears error
    fetch(32'h8000_0018, 0, 0, 32'hCAFE_0000, 32'hCAFE_0004, 2'b00, 2'b10, 1'b0, 0,
          64'hCAFE_0004_CAFE_0000, 1'b1);
    fetch(32'h8000_0020, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 2'b00, 1'b0, 0,
          64'h9ABC_DEF0_1234_5678, 1'b0);
    // 5: beats 3 cycles apart
    fetch(32'h0040_0008, 2, 2, 32'h0000_00AA, 32'h0000_00BB, 2'b00, 2'b00, 1'b0, 0,
          64'h0000_00BB_0000_00AA, 1'b0);
    // early rlast on beat 0: upper half zero, error flagged
    fetch(32'h0040_0030, 0, 0, 32'h7777_7777, 32'h0, 2'b00, 2'b00, 1'b1, 0,
          64'h0000_0000_7777_7777, 1'b1);
    // flush in DONE suppresses the pulse
    fetch(32'h0040_0040, 0, 0, 32'h1, 32'h2, 2'b00, 2'b00, 1'b0, 2, 64'h0, 1'b0);

    // flush in IDLE: request not started, stall still follows en
    inst_sram_en = 1'b1; flush = 1'b1; inst_sram_addr = 32'h0000_2000;
    #1;
    chk("iflush_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("iflush_state", dbg_state, 0);
    chk("iflush_arvalid", arvalid, 0);
    inst_sram_en = 1'b0; flush = 1'b0;
    @(negedge clk);

    // 6: reset during R
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_3000;
    @(negedge clk);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    beat(0, 32'hFFFF_0000, 2'b00, 1'b0);
    #1;
    chk("prerst_state", dbg_state, 2);
    reset = 1'b1;
    #1;
    chk("midrst_state", dbg_state, 0);
    chk("midrst_arvalid", arvalid, 0);
    chk("midrst_rready", rready, 0);
    chk("midrst_rvalid", inst_rvalid, 0);
    chk("midrst_stall_en1", stall, 1);
    inst_sram_en = 1'b0;
    #1;
    chk("midrst_stall_en0", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    fetch(32'h0000_3008, 0, 1, 32'hBEEF_0001, 32'hBEEF_0002, 2'b00, 2'b00, 1'b0, 0,
          64'hBEEF_0002_BEEF_0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
